// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit: 32-cycle shift-add / restoring divide with a one-cycle sign fix.
// Define MULDIV_DIV_EN to compile in the divide datapath; otherwise divide ops finish at once with zero.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  funct3,
    output logic        busy,
    output logic        ready,
    output logic [31:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [2:0]  op;
    logic [31:0] opnd;      // multiplicand for multiply, divisor for divide
    logic [63:0] acc;       // {hi, lo}: product, or {remainder, quotient}
    logic [5:0]  cnt;
    logic        a_neg, b_neg;

    logic        a_sgn, b_sgn, a_is_neg, b_is_neg;
    logic [31:0] a_abs, b_abs;
    logic [32:0] sum;
    logic [63:0] mul_nxt, prod;
    logic [31:0] mul_res, fix_res;

    always_comb begin
        if (funct3[2]) begin
            a_sgn = ~funct3[0];
            b_sgn = ~funct3[0];
        end else begin
            a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010);
            b_sgn = (funct3 == 3'b001);
        end
        a_is_neg = a_sgn & A[31];
        b_is_neg = b_sgn & B[31];
        a_abs    = a_is_neg ? (~A + 32'd1) : A;
        b_abs    = b_is_neg ? (~B + 32'd1) : B;
    end

    // Multiply step: add multiplicand into the high half when the low multiplier bit is set, shift right.
    always_comb begin
        sum     = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
        mul_nxt = {sum, acc[31:1]};
        prod    = (a_neg ^ b_neg) ? (~acc + 64'd1) : acc;
        mul_res = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end

`ifdef MULDIV_DIV_EN
    logic [32:0] shl, diff;
    logic [63:0] div_nxt;
    logic [31:0] quo_s, rem_s;
    logic        div_zero, div_ovf;

    // Restoring step: remainder < divisor always, so diff[32] is a true borrow flag.
    always_comb begin
        shl      = {acc[63:32], acc[31]};
        diff     = shl - {1'b0, opnd};
        div_nxt  = diff[32] ? {shl[31:0], acc[30:0], 1'b0}
                            : {diff[31:0], acc[30:0], 1'b1};
        quo_s    = (a_neg ^ b_neg) ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_s    = a_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
        fix_res  = op[2] ? (op[1] ? rem_s : quo_s) : mul_res;
        div_zero = funct3[2] && (B == 32'd0);
        div_ovf  = funct3[2] && !funct3[0] && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    end
`else
    always_comb begin
        fix_res = op[2] ? 32'd0 : mul_res;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op     <= '0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        a_neg <= a_is_neg;
                        b_neg <= b_is_neg;
                        opnd  <= funct3[2] ? b_abs : a_abs;
                        acc   <= {32'd0, (funct3[2] ? a_abs : b_abs)};
                        cnt   <= '0;
`ifdef MULDIV_DIV_EN
                        if (div_zero) begin
                            result <= funct3[1] ? A : 32'hFFFF_FFFF;
                            state  <= DONE;
                        end else if (div_ovf) begin
                            result <= funct3[1] ? 32'd0 : 32'h8000_0000;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
`else
                        if (funct3[2]) begin
                            result <= '0;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
`endif
                    end
                end
                CALC: begin
`ifdef MULDIV_DIV_EN
                    acc <= op[2] ? div_nxt : mul_nxt;
`else
                    acc <= mul_nxt;
`endif
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == CALC) || (state == FIX);
    assign ready = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a negedge monitor checks ready/result/busy.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] A, B;
    logic [2:0]  funct3;
    logic        busy, ready;
    logic [31:0] result;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .funct3(funct3),
        .busy(busy), .ready(ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] last_res = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the RV32M definitions.
    task automatic model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        logic [63:0] ea, eb, p;
        int sa, sb;
        if (!f[2]) begin
            ea  = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
            eb  = (f == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
            p   = ea * eb;
            res = (f == 3'b000) ? p[31:0] : p[63:32];
            lat = 34;
        end else begin
`ifdef MULDIV_DIV_EN
            sa = a;
            sb = b;
            lat = 34;
            if (b == 32'd0) begin
                res = f[1] ? a : 32'hFFFF_FFFF;
                lat = 1;
            end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                res = f[1] ? 32'd0 : 32'h8000_0000;
                lat = 1;
            end else if (!f[0]) begin
                res = f[1] ? (sa % sb) : (sa / sb);
            end else begin
                res = f[1] ? (a % b) : (a / b);
            end
`else
            sa  = 0;
            sb  = 0;
            res = 32'd0;
            lat = 1;
`endif
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        A      = a;
        B      = b;
        funct3 = f;
        model(f, a, b, e.res, e.lat);
        e.t0 = cyc;
        sbq.push_back(e);
    endtask

    // Wait for ready; with noise, start/operands are scrambled while the op runs.
    task automatic wait_ready(input bit noise);
        bit got = 1'b0;
        int n = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            got    = ready;
            start  = (noise && !got) ? 1'($urandom_range(0, 1)) : 1'b0;
            A      = $urandom;
            B      = $urandom;
            funct3 = 3'($urandom);
            n++;
        end
        if (!got) begin
            n_assert++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready after %0d cycles, required ready", n);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit noise);
        issue(f, a, b);
        wait_ready(noise);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops an expectation on every ready, checks busy and result hold every cycle.
    always @(negedge clk) begin
        int   el;
        logic exp_busy;
        exp_t e;
        if (!rst) begin
            exp_busy = 1'b0;
            el = 0;
            if (sbq.size() != 0) begin
                el = cyc - sbq[0].t0;
                exp_busy = (el >= 1) && (el < sbq[0].lat);
            end
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_ready", {31'd0, ready}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("result", result, e.res);
                    chk("latency", el, e.lat);
                    last_res = e.res;
                end
            end else begin
                chk("result_hold", result, last_res);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; funct3 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_result", result, 32'd0);
        #1 rst = 1'b0;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'b101, 32'd100, 32'd7, 1'b0);
        run_op(3'b101, 32'd5, 32'd0, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b111, 32'd9, 32'd0, 1'b0);
        run_op(3'b100, 32'd10, 32'd2, 1'b0);
        run_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        // Abort a multiply in cycle 10 of its run.
        issue(3'b000, 32'h0001_0001, 32'h0000_FFFF);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        sbq.delete();
        last_res = 32'd0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        run_op(3'b000, 32'd3, 32'd4, 1'b0);
        run_op(3'b000, 32'd6, 32'd7, 1'b0);

        for (int i = 0; i < 200; i++)
            run_op(3'($urandom), pick(), pick(), 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
